// File: rtl/dmem_vec_sequencer.sv
// Arbiter/sequencer sharing one data-memory word port between scalar accesses and
// six-beat vector transfers. Optional bounds check: define DMEM_SEQ_BOUNDS_CHECK_EN.
module dmem_vec_sequencer #(
   parameter int S     = 32,
   parameter int V     = 192,
   parameter int LANES = 6,
   parameter int SIZE  = 30015
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         s_req,
   input  logic         s_we,
   input  logic [S-1:0] s_addr,
   input  logic [S-1:0] s_wd,
   output logic         s_gnt,
   output logic [S-1:0] s_rd,
   output logic         s_rvalid,
   input  logic         v_req,
   input  logic         v_we,
   input  logic [S-1:0] v_addr,
   input  logic [V-1:0] v_wd,
   output logic         v_gnt,
   output logic         v_busy,
   output logic         v_done,
   output logic [V-1:0] v_rd,
   output logic         m_we,
   output logic [S-1:0] m_addr,
   output logic [S-1:0] m_wd,
   input  logic [S-1:0] m_rd,
   output logic         err
);

   localparam int BW = $clog2(LANES);

`ifdef DMEM_SEQ_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   typedef enum logic {IDLE, VEC} state_t;

   state_t        state;
   logic [BW-1:0] beat;
   logic [S-1:0]  base;
   logic [V-1:0]  vdata;
   logic          dir;
   logic          v_oob;
   logic          s_oob_c;
   logic          v_oob_c;
   logic [S-1:0]  lane_wd;

   // Range math is done one bit wider so a base near 2^S cannot wrap past the check.
   assign s_oob_c = BOUNDS_EN && ({1'b0, s_addr} >= (S+1)'(SIZE));
   assign v_oob_c = BOUNDS_EN && (({1'b0, v_addr} + (S+1)'(LANES-1)) >= (S+1)'(SIZE));

   assign s_gnt   = rst_n && (state == IDLE) && s_req;
   assign v_gnt   = rst_n && (state == IDLE) && v_req && !s_req;
   assign v_busy  = (state == VEC);
   assign lane_wd = vdata[int'(beat)*S +: S];

   // Port outputs are gated by rst_n so an aborted beat never reaches the RAM.
   always_comb begin
      m_we   = 1'b0;
      m_addr = '0;
      m_wd   = '0;
      if (rst_n) begin
         if (state == VEC) begin
            m_addr = base + S'(beat);
            m_wd   = lane_wd;
            m_we   = dir && !v_oob;
         end else if (s_gnt) begin
            m_addr = s_addr;
            m_wd   = s_wd;
            m_we   = s_we && !s_oob_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         beat     <= '0;
         base     <= '0;
         vdata    <= '0;
         dir      <= 1'b0;
         v_oob    <= 1'b0;
         s_rd     <= '0;
         s_rvalid <= 1'b0;
         v_done   <= 1'b0;
         v_rd     <= '0;
         err      <= 1'b0;
      end else begin
         s_rvalid <= 1'b0;
         v_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (s_gnt) begin
                  s_rd     <= s_oob_c ? '0 : m_rd;
                  s_rvalid <= !s_we;
                  if (s_oob_c) err <= 1'b1;
               end else if (v_gnt) begin
                  base  <= v_addr;
                  vdata <= v_wd;
                  dir   <= v_we;
                  v_oob <= v_oob_c;
                  beat  <= '0;
                  state <= VEC;
                  if (v_oob_c) err <= 1'b1;
               end
            end
            VEC: begin
               if (!dir) v_rd[int'(beat)*S +: S] <= v_oob ? '0 : m_rd;
               if (beat == BW'(LANES-1)) begin
                  state  <= IDLE;
                  beat   <= '0;
                  v_done <= 1'b1;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_vec_sequencer.sv
// Directed bench for dmem_vec_sequencer: a RAM model on the memory port, driver tasks,
// and a monitor that checks s_rd / v_rd against expected queues when valid pulses appear.
module tb_dmem_vec_sequencer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         s_req, s_we;
   logic [31:0]  s_addr, s_wd, s_rd;
   logic         s_gnt, s_rvalid;
   logic         v_req, v_we;
   logic [31:0]  v_addr;
   logic [191:0] v_wd, v_rd;
   logic         v_gnt, v_busy, v_done;
   logic         m_we;
   logic [31:0]  m_addr, m_wd, m_rd;
   logic         err;

`ifdef DMEM_SEQ_BOUNDS_CHECK_EN
   localparam bit BCHK = 1'b1;
`else
   localparam bit BCHK = 1'b0;
`endif

   always #5 clk = ~clk;

   dmem_vec_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wd(s_wd),
      .s_gnt(s_gnt), .s_rd(s_rd), .s_rvalid(s_rvalid),
      .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wd(v_wd),
      .v_gnt(v_gnt), .v_busy(v_busy), .v_done(v_done), .v_rd(v_rd),
      .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd), .m_rd(m_rd), .err(err)
   );

   // RAM model: combinational read, write on negedge.
   logic [31:0] mem [0:32767];
   assign m_rd = mem[m_addr[14:0]];
   always @(negedge clk) if (m_we) mem[m_addr[14:0]] <= m_wd;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0]  s_exp_q[$];
   logic [191:0] v_exp_q[$];
   logic [191:0] last_vrd = '0;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT presents read data.
   always @(negedge clk) begin
      if (rst_n) begin
         if (s_rvalid) begin
            if (s_exp_q.size() == 0) chk("s_rvalid_unexpected", 1, 0);
            else chk("s_rd", s_rd, s_exp_q.pop_front());
         end
         if (v_done) begin
            if (v_exp_q.size() == 0) chk("v_done_unexpected", 1, 0);
            else chk("v_rd", v_rd, v_exp_q.pop_front());
         end
      end
   end

   function automatic logic [191:0] lanes6(input logic [31:0] l0, l1, l2, l3, l4, l5);
      return {l5, l4, l3, l2, l1, l0};
   endfunction

   // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
   task automatic scalar_op(input logic we, input logic [31:0] addr, wd, exp);
      s_req = 1'b1; s_we = we; s_addr = addr; s_wd = wd;
      @(negedge clk);
      chk("s_gnt", s_gnt, 1);
      chk("s_m_addr", m_addr, addr);
      chk("s_m_we", m_we, we && !(BCHK && addr >= 32'd30015));
      if (!we) s_exp_q.push_back(exp);
      @(posedge clk); #1;
      s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wd = '0;
   endtask

   task automatic vec_op(input logic we, input logic [31:0] addr, input logic [191:0] wd,
                         input logic [191:0] exp_rd, input logic oob);
      v_req = 1'b1; v_we = we; v_addr = addr; v_wd = wd;
      @(negedge clk);
      chk("v_gnt", v_gnt, 1);
      if (we) v_exp_q.push_back(last_vrd);
      else begin
         v_exp_q.push_back(exp_rd);
         last_vrd = exp_rd;
      end
      @(posedge clk); #1;
      v_req = 1'b0; v_we = 1'b0; v_addr = '0; v_wd = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("v_busy", v_busy, 1);
         chk("v_m_addr", m_addr, addr + k);
         chk("v_m_we", m_we, we && !oob);
         if (we) chk("v_m_wd", m_wd, wd[k*32 +: 32]);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("v_busy_end", v_busy, 0);
      chk("v_done", v_done, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = '0;
      rst_n = 1'b0;
      s_req = 1'b1; s_we = 1'b0; s_addr = 32'd5; s_wd = '0;
      v_req = 1'b1; v_we = 1'b0; v_addr = 32'd7; v_wd = '0;

      // Reset with both requests asserted.
      repeat (3) begin
         @(negedge clk);
         chk("rst_s_gnt", s_gnt, 0);
         chk("rst_v_gnt", v_gnt, 0);
         chk("rst_m_we", m_we, 0);
         chk("rst_m_addr", m_addr, 0);
         chk("rst_outs", {s_rvalid, v_busy, v_done, err}, 0);
         chk("rst_s_rd", s_rd, 0);
         chk("rst_v_rd", v_rd, 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; s_req = 1'b0; v_req = 1'b0; s_addr = '0; v_addr = '0;

      // Scalar write then read back, plus an untouched address.
      scalar_op(1'b1, 32'd10, 32'hDEADBEEF, '0);
      scalar_op(1'b0, 32'd10, '0, 32'hDEADBEEF);
      scalar_op(1'b0, 32'd11, '0, 32'h0);

      // Vector write lanes 1..6 at base 100, then read back.
      vec_op(1'b1, 32'd100, lanes6(1, 2, 3, 4, 5, 6), '0, 1'b0);
      vec_op(1'b0, 32'd100, '0, lanes6(1, 2, 3, 4, 5, 6), 1'b0);

      // Tie: scalar wins, vector granted next cycle; scalar stalled until T+7.
      s_req = 1'b1; s_we = 1'b0; s_addr = 32'd10;
      v_req = 1'b1; v_we = 1'b0; v_addr = 32'd100;
      @(negedge clk);
      chk("tie_s_gnt", s_gnt, 1);
      chk("tie_v_gnt", v_gnt, 0);
      s_exp_q.push_back(32'hDEADBEEF);
      @(posedge clk); #1;
      s_req = 1'b0;
      @(negedge clk);
      chk("tie_v_gnt2", v_gnt, 1);
      v_exp_q.push_back(lanes6(1, 2, 3, 4, 5, 6));
      last_vrd = lanes6(1, 2, 3, 4, 5, 6);
      @(posedge clk); #1;
      v_req = 1'b0; s_req = 1'b1; s_addr = 32'd11;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("stall_s_gnt", s_gnt, 0);
         chk("stall_v_busy", v_busy, 1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("t7_s_gnt", s_gnt, 1);
      chk("t7_v_done", v_done, 1);
      s_exp_q.push_back(32'h0);
      @(posedge clk); #1;
      s_req = 1'b0; s_addr = '0;

      // Reset during beat 3 of a vector write at base 200.
      v_req = 1'b1; v_we = 1'b1; v_addr = 32'd200;
      v_wd = lanes6(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5);
      @(negedge clk);
      chk("abort_v_gnt", v_gnt, 1);
      @(posedge clk); #1;
      v_req = 1'b0; v_we = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_m_we", m_we, 1);
         chk("abort_m_addr", m_addr, 200 + k);
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_m_we_rst", m_we, 0);
      @(posedge clk); #1;
      rst_n = 1'b1; v_wd = '0; v_addr = '0;
      last_vrd = '0;
      @(negedge clk);
      chk("abort_v_busy", v_busy, 0);
      chk("abort_v_done", v_done, 0);
      @(posedge clk); #1;
      vec_op(1'b0, 32'd200, '0, lanes6(32'hA0, 32'hA1, 32'hA2, 0, 0, 0), 1'b0);

      // Vector write running past the end of memory.
      chk("err_before", err, 0);
      vec_op(1'b1, 32'd30012, lanes6(32'h5A5A0000, 1, 2, 3, 4, 5), '0, BCHK);
      chk("err_after", err, BCHK);
      scalar_op(1'b0, 32'd30012, '0, BCHK ? 32'h0 : 32'h5A5A0000);
      chk("err_sticky", err, BCHK);

      repeat (2) @(posedge clk);
      #1;
      chk("s_q_empty", s_exp_q.size(), 0);
      chk("v_q_empty", v_exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
